// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with a valid/ready byte output and single-cycle error pulses.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int BIT_DIV     = 186,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR
);

  localparam int TW = $clog2(BIT_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] HALF   = TW'(BIT_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_q;
  state_t                 state;
  logic [TW-1:0]          timer;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  logic                   par_bad;
  logic                   good;
  logic                   ferr_pend;
  logic                   perr_pend;
  logic                   tick;

  assign rx_s = sync[SYNC_STAGES-1];
  assign tick = (timer == '0);
  assign BUSY = (state != S_IDLE);

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the synchronizer resets to the idle line level so leaving reset
      // never looks like a falling start edge.
      sync       <= '1;
      rx_q       <= 1'b1;
      state      <= S_IDLE;
      timer      <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      good       <= 1'b0;
      ferr_pend  <= 1'b0;
      perr_pend  <= 1'b0;
      DATA       <= '0;
      VALID      <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], RXD};
      rx_q      <= rx_s;
      good      <= 1'b0;
      ferr_pend <= 1'b0;
      perr_pend <= 1'b0;

      // Half-period load on the start edge puts every later tick at a bit centre.
      if (state == S_IDLE) begin
        if (rx_q && !rx_s) timer <= HALF;
      end else if (tick) begin
        timer <= RELOAD;
      end else begin
        timer <= timer - 1'b1;
      end

      case (state)
        S_IDLE:  if (rx_q && !rx_s) state <= S_START;
        S_START: if (tick) begin
          if (rx_s) state <= S_IDLE;
          else begin
            idx   <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: if (tick) begin
          shreg <= {rx_s, shreg[7:1]};
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick) begin
          par_bad <= ^{shreg, rx_s};
          state   <= S_STOP;
        end
`endif
        S_STOP: if (tick) begin
          if (rx_s) begin
            state <= S_IDLE;
            if (par_bad) perr_pend <= 1'b1;
            else         good      <= 1'b1;
          end else begin
            ferr_pend <= 1'b1;
            state     <= S_BREAK;
          end
        end
        S_BREAK: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Delivery one cycle after the stop sample; an accept in that cycle frees the slot.
      FRAME_ERR <= ferr_pend;
      OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= perr_pend;
`else
      PARITY_ERR <= 1'b0;
`endif
      if (good && (!VALID || READY)) begin
        DATA  <= shreg;
        VALID <= 1'b1;
      end else begin
        if (good) OVERRUN <= 1'b1;
        if (VALID && READY) VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level event model plus directed scenario checks.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int BIT_DIV     = 16;
  localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edge seen SYNC_STAGES+1 after the line drops, start centre BIT_DIV/2 later,
  // stop centre FRAME_BITS-1 periods after that, outputs change one cycle later.
  localparam int DUE = SYNC_STAGES + 1 + BIT_DIV / 2 + BIT_DIV * (FRAME_BITS - 1) + 1;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RXD;
  logic       READY;
  logic [7:0] DATA;
  logic       VALID;
  logic       BUSY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;

  uart_rx #(.BIT_DIV(BIT_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RESET(RESET), .RXD(RXD), .DATA(DATA), .VALID(VALID), .READY(READY),
    .BUSY(BUSY), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  typedef enum {EV_GOOD, EV_FERR, EV_PERR} ev_kind_t;
  typedef struct {
    int         due;
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] got[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         perr_cnt = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_perr = 1'b0;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: each frame produces one outcome at a known cycle.
  always @(posedge CLK) begin
    ev_t ev;
    logic load;
    cyc++;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
    if (RESET) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      load = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          EV_GOOD: if (!m_valid || READY) load = 1'b1; else m_ovr = 1'b1;
          EV_FERR: m_ferr = 1'b1;
          EV_PERR: m_perr = 1'b1;
          default: ;
        endcase
      end
      if (load) begin
        m_valid = 1'b1;
        m_data  = ev.data;
      end else if (m_valid && READY) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process and pulse/byte logging, just after each active edge.
  always @(posedge CLK) begin
    #1;
    if (cyc >= 1) begin
      check("valid", VALID, m_valid);
      if (m_valid) check("data", DATA, m_data);
      check("frame_err", FRAME_ERR, m_ferr);
      check("overrun", OVERRUN, m_ovr);
      check("parity_err", PARITY_ERR, m_perr);
      if (FRAME_ERR === 1'b1) ferr_cnt++;
      if (OVERRUN === 1'b1) ovr_cnt++;
      if (PARITY_ERR === 1'b1) perr_cnt++;
      if (VALID === 1'b1 && (!pv || DATA != pd)) got.push_back(DATA);
      pv = VALID;
      pd = DATA;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic v);
    RXD = v;
    repeat (BIT_DIV) @(negedge CLK);
  endtask

  // Called on a negedge; drives one whole frame and predicts its outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    ev_t ev;
    logic par;
    par     = (^b) ^ par_flip;
    ev.due  = cyc + DUE;
    ev.data = b;
    ev.kind = EV_GOOD;
    if (!stop) ev.kind = EV_FERR;
`ifdef UART_RX_PARITY_EN
    else if (par_flip) ev.kind = EV_PERR;
`endif
    evq.push_back(ev);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int f0, o0, p0;
    RXD   = 1'b1;
    READY = 1'b1;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_data", DATA, 8'h00);
    check("reset_valid", VALID, 1'b0);
    check("reset_busy", BUSY, 1'b0);
    check("reset_ferr", FRAME_ERR, 1'b0);
    check("reset_ovr", OVERRUN, 1'b0);
    check("reset_perr", PARITY_ERR, 1'b0);
    RESET = 1'b0;
    idle(5);

    // Back-to-back frames.
    got.delete();
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    idle(20);
    check("b2b_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("b2b_byte0", got[0], 8'h55);
      check("b2b_byte1", got[1], 8'hA3);
    end
    check("b2b_pulses", (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 0);

    // Short low glitch.
    got.delete();
    cnt = 0;
    RXD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (BUSY) cnt++;
    end
    RXD = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (BUSY) cnt++;
    end
    check("glitch_busy_range", (cnt >= 1 && cnt <= 10), 1'b1);
    check("glitch_idle", BUSY, 1'b0);
    check("glitch_no_byte", got.size(), 0);

    // Bad stop bit followed by a held-low line.
    got.delete();
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    check("break_busy", BUSY, 1'b1);
    RXD = 1'b1;
    cnt = 0;
    while (BUSY && cnt < 10) begin
      @(negedge CLK);
      cnt++;
    end
    check("break_release", (cnt >= 1 && cnt <= 3), 1'b1);
    idle(20);
    check("break_one_ferr", ferr_cnt - f0, 1);
    check("break_no_byte", got.size(), 0);
    check("break_valid", VALID, 1'b0);

    // Overrun while the holding register is full.
    o0 = ovr_cnt;
    READY = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(10);
    check("ovr_data", DATA, 8'h11);
    check("ovr_valid", VALID, 1'b1);
    check("ovr_count", ovr_cnt - o0, 1);
    READY = 1'b1;
    idle(2);
    check("ovr_drain_valid", VALID, 1'b0);
    check("ovr_drain_data", DATA, 8'h11);

    // Accept in the very cycle the next byte is delivered.
    READY = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0);
    idle(10);
    check("sim_first_data", DATA, 8'h01);
    check("sim_first_valid", VALID, 1'b1);
    o0 = ovr_cnt;
    fork
      send_frame(8'h02, 1'b1, 1'b0);
      begin
        repeat (DUE - 1) @(negedge CLK);
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
      end
    join
    idle(10);
    check("sim_no_ovr", ovr_cnt - o0, 0);
    check("sim_data", DATA, 8'h02);
    check("sim_valid", VALID, 1'b1);
    READY = 1'b1;
    idle(2);
    check("sim_drain", VALID, 1'b0);

    // Reset in the middle of data bit 3.
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BIT_DIV * 4 + 8) @(negedge CLK);
        check("mid_busy_before", BUSY, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mid_data", DATA, 8'h00);
        check("mid_valid", VALID, 1'b0);
        check("mid_busy", BUSY, 1'b0);
        check("mid_pulses", {FRAME_ERR, OVERRUN, PARITY_ERR}, 3'b000);
      end
    join
    idle(20);
    got.delete();
    p0 = perr_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(20);
    check("post_perr", perr_cnt - p0, 1);
    check("post_no_byte", got.size(), 0);
    check("post_valid", VALID, 1'b0);
`else
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(20);
    check("post_count", got.size(), 1);
    if (got.size() >= 1) check("post_byte", got[0], 8'h7E);
    check("post_perr", perr_cnt - p0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver for the board's debug/host UART link, 8N1, LSB first.
- Counterpart of the existing UART transmit path. Instantiated with it when the board's UART module is enabled.
- Converts the RXD pin into bytes delivered over a valid/ready handshake to the cartridge register interface.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- BIT_DIV, 186, CLK cycles per bit period; must be >= 8.
- SYNC_STAGES, 2, input synchronizer depth; must be >= 2.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- RXD  input  1  raw serial line from pin; idle high; asynchronous to CLK
- DATA  output  8  received byte; stable while VALID=1
- VALID  output  1  DATA holds an unconsumed byte
- READY  input  1  consumer accepts DATA when VALID&&READY
- BUSY  output  1  a frame is in progress (state != IDLE)
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
- OVERRUN  output  1  one-cycle pulse: good frame dropped because the holding register was full
- PARITY_ERR  output  1  one-cycle pulse: parity mismatch; tied 0 without the optional feature

Behaviour:
- Reset values: DATA=8'h00, VALID=0, BUSY=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0. Synchronizer flops reset to 1. State=IDLE. Counters=0.
  - Reset mid-frame aborts the frame with no pulses.
  - A byte held at reset is lost.
- Synchronizer: SYNC_STAGES flops; rx_s is the last stage. rx_q is a further flop used for edge detection.
- Bit timer: down-counter of $clog2(BIT_DIV) bits. "Tick" means the counter is 0; on a tick it reloads BIT_DIV-1.
- State machine:
  - IDLE: on rx_q=1 && rx_s=0 (falling edge), load timer with BIT_DIV/2-1 (integer division) and go to START.
  - START: on tick, sample rx_s.
    - 1: glitch. Return to IDLE; no pulse.
    - 0: clear the bit index, go to DATA.
  - DATA: on each tick, shift rx_s into shreg[7] (right shift, so LSB first). After the 8th sample go to STOP, or to PARITY if the feature is compiled in.
  - STOP: on tick, sample rx_s.
    - 1: frame good. Go to IDLE.
    - 0: FRAME_ERR=1 for one cycle, byte discarded, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. Lets a line held low (break) produce exactly one FRAME_ERR.
- Sampling point is the bit centre (±1 CLK). With an exact BIT_DIV this tolerates ±4% baud mismatch.
- Good-frame delivery happens on the cycle after the stop tick (call it T+1):
  - If VALID=0, or VALID&&READY in cycle T+1: DATA<=shreg and VALID<=1. The simultaneous accept-and-load gives no overrun.
  - Else (VALID=1, READY=0): DATA is unchanged, the new byte is dropped, and OVERRUN=1 for one cycle.
- Handshake:
  - VALID falls the cycle after VALID&&READY unless a new byte loads in that same cycle.
  - READY while VALID=0 is ignored.
- Latency: the RXD falling edge is seen after SYNC_STAGES+1 CLK. VALID rises 1 CLK after the stop-bit centre tick.
- BUSY=1 in START, DATA, PARITY, STOP and BREAK.
- A new start edge is accepted in IDLE on the cycle immediately after a good stop sample. Back-to-back frames with no idle gap are supported.
- Pulses never overlap: a frame produces at most one of FRAME_ERR, OVERRUN or PARITY_ERR.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP. One tick samples the parity bit.
  - Even parity expected: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, the frame is still checked for its stop bit. If the stop bit is good: PARITY_ERR pulse at T+1, byte discarded, VALID unaffected. A bad stop bit takes precedence as FRAME_ERR.
- Not defined: no PARITY state, 10-bit frames, PARITY_ERR tied 0.

Test Plan (BIT_DIV=16, SYNC_STAGES=2, READY=1 unless stated):
- Drive 0x55 then 0xA3 as 8N1 frames with no gap -> two VALID cycles; DATA=8'h55 then 8'hA3; no error pulses.
- 6-CLK low glitch on idle RXD -> return to IDLE; BUSY high for at most 10 cycles; VALID stays 0.
- Frame 0x3C with stop bit low, then RXD held low 40 cycles -> exactly one FRAME_ERR pulse; VALID=0; BUSY falls 1–3 CLK after RXD returns high.
- READY=0; send 0x11 then 0x22 -> DATA=8'h11, VALID=1, one OVERRUN pulse. Raise READY -> VALID drops; DATA remains 8'h11.
- Byte 0x01 held with READY=0; assert READY exactly in the delivery cycle of 0x02 -> no OVERRUN; DATA=8'h02, VALID stays 1.
- RESET asserted mid-frame (bit 3 of 0xFF) -> all outputs at reset values next cycle. The next clean frame 0x7E is received correctly; with UART_RX_PARITY_EN, 0x7E with parity bit 1 -> one PARITY_ERR pulse and VALID=0.
